// File: rtl/piso_tx.sv
// Parallel-in serial-out byte transmitter: start bit, 8 data bits LSB first,
// optional even parity bit, stop bit; each bit held CLKS_PER_BIT clocks.
module piso_tx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic       clk,
    input  logic       clear_n,
    input  logic [7:0] din,
    input  logic       load,
    output logic       ready,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] state_dbg
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    // Handshake: load is accepted on any rising edge where load=1 and ready=1;
    // while ready=0, load is ignored and not remembered.

    state_t      state, state_nxt;
    logic [15:0] timer, timer_nxt;
    logic [2:0]  idx, idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic        done_q, done_nxt;
    logic        bit_end;

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state  <= IDLE;
            timer  <= '0;
            idx    <= '0;
            shreg  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            timer  <= timer_nxt;
            idx    <= idx_nxt;
            shreg  <= shreg_nxt;
            done_q <= done_nxt;
        end
    end

    assign bit_end = (timer == LAST);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        idx_nxt   = idx;
        shreg_nxt = shreg;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                idx_nxt   = '0;
                if (load) begin
                    shreg_nxt = din;
                    state_nxt = START;
                end
            end
            START: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    state_nxt = DATA;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    idx_nxt   = idx + 3'd1;
                    if (idx == 3'd7)
                        state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    state_nxt = STOP;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
                idx_nxt   = '0;
            end
        endcase
    end

    // Line level is decoded from registered state so tx drops in the cycle
    // right after the accept edge.
    always_comb begin
        tx = 1'b1;
        case (state)
            START:   tx = 1'b0;
            DATA:    tx = shreg[idx];
            PARITY:  tx = ^shreg;
            default: tx = 1'b1;
        endcase
    end

    assign ready     = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign state_dbg = state;

endmodule
